// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Purpose  : Instruction fetch unit: requests words from instruction memory,
//            holds them in IR until retired, follows branches, stops on halt.
// Revision : 1.0
// ============================================================================
module instr_fetch #(
   parameter int                 ADDR_W   = 16,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_f,
   input  logic              next,
   input  logic              br_taken,
   input  logic [ADDR_W-1:0] br_addr,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [31:0]       mem_data,
   output logic [31:0]       ir,
   output logic              ir_valid,
   output logic [ADDR_W-1:0] pc,
   output logic              halted,
   output logic [15:0]       instr_cnt
);

   localparam logic [3:0] c_HALT_OP = 4'hF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2,
      HALT  = 2'd3
   } state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_fetch_addr;

   // The fetch address register drives memory directly, so it is stable
   // for as long as the request is held.
   assign mem_addr = r_fetch_addr;

   always_ff @(posedge clk) begin
      if (rst_f) begin
         r_state      <= IDLE;
         r_fetch_addr <= RESET_PC;
         ir           <= '0;
         ir_valid     <= 1'b0;
         pc           <= RESET_PC;
         mem_req      <= 1'b0;
         halted       <= 1'b0;
         instr_cnt    <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               r_state <= FETCH;
               mem_req <= 1'b1;
            end
            FETCH: begin
               if (mem_ack) begin
                  ir           <= mem_data;
                  pc           <= r_fetch_addr;
                  r_fetch_addr <= r_fetch_addr + ADDR_W'(1);
                  ir_valid     <= 1'b1;
                  mem_req      <= 1'b0;
                  if (instr_cnt != 16'hFFFF)
                     instr_cnt <= instr_cnt + 16'd1;
                  if (mem_data[31:28] == c_HALT_OP) begin
                     r_state <= HALT;
                     halted  <= 1'b1;
                  end else begin
                     r_state <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (next) begin
                  ir_valid <= 1'b0;
                  mem_req  <= 1'b1;
                  r_state  <= FETCH;
                  if (br_taken)
                     r_fetch_addr <= br_addr;
               end
            end
            HALT: begin
               r_state <= HALT;
            end
            default: begin
               r_state <= IDLE;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch
// Purpose  : Random and directed stimulus for instr_fetch against a
//            transaction-level reference model.
// Revision : 1.0
// ============================================================================
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst_f = 1'b1, next = 1'b0, br_taken = 1'b0, mem_ack = 1'b0;
   logic [15:0] br_addr = '0;
   logic        mem_req, ir_valid, halted;
   logic [15:0] mem_addr, pc, instr_cnt;
   logic [31:0] mem_data, ir;

   logic        rst_w = 1'b1, next_w = 1'b0, ack_w = 1'b0;
   logic        mem_req_w, ir_valid_w, halted_w;
   logic [15:0] mem_addr_w, pc_w, instr_cnt_w;
   logic [31:0] mem_data_w, ir_w;

   logic [31:0] mem [0:65535];
   logic [31:0] words [5];

   int n_cmp = 0, n_err = 0;
   bit chk_en = 1'b0;

   // reference model: 0 waiting after reset, 1 requesting, 2 holding, 3 halted
   int          m_mode = 0;
   logic [15:0] m_addr = '0, m_pc = '0;
   logic [31:0] m_ir = '0;
   logic        m_irv = 1'b0, m_halted = 1'b0;
   int          m_cnt = 0;

   assign mem_data   = mem[mem_addr];
   assign mem_data_w = mem[mem_addr_w];

   instr_fetch #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
      .clk(clk), .rst_f(rst_f), .next(next), .br_taken(br_taken),
      .br_addr(br_addr), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_ack(mem_ack), .mem_data(mem_data), .ir(ir), .ir_valid(ir_valid),
      .pc(pc), .halted(halted), .instr_cnt(instr_cnt)
   );

   instr_fetch #(.ADDR_W(16), .RESET_PC(16'hFFFF)) dut_w (
      .clk(clk), .rst_f(rst_w), .next(next_w), .br_taken(1'b0),
      .br_addr(16'h0000), .mem_req(mem_req_w), .mem_addr(mem_addr_w),
      .mem_ack(ack_w), .mem_data(mem_data_w), .ir(ir_w), .ir_valid(ir_valid_w),
      .pc(pc_w), .halted(halted_w), .instr_cnt(instr_cnt_w)
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model advances on each rising edge from the inputs the DUT sees.
   always @(posedge clk) begin
      if (rst_f) begin
         m_mode = 0; m_addr = 16'h0000; m_pc = 16'h0000; m_ir = '0;
         m_irv = 1'b0; m_halted = 1'b0; m_cnt = 0;
      end else if (m_mode == 0) begin
         m_mode = 1;
      end else if (m_mode == 1 && mem_ack) begin
         m_ir  = mem[m_addr];
         m_pc  = m_addr;
         m_addr = m_addr + 16'd1;
         m_irv = 1'b1;
         m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
         if (m_ir[31:28] == 4'hF) begin
            m_mode = 3; m_halted = 1'b1;
         end else begin
            m_mode = 2;
         end
      end else if (m_mode == 2 && next) begin
         m_irv  = 1'b0;
         m_mode = 1;
         if (br_taken) m_addr = br_addr;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("ir", ir, m_ir);
         chk("ir_valid", {31'b0, ir_valid}, {31'b0, m_irv});
         chk("pc", {16'b0, pc}, {16'b0, m_pc});
         chk("halted", {31'b0, halted}, {31'b0, m_halted});
         chk("instr_cnt", {16'b0, instr_cnt}, 32'(m_cnt));
         chk("mem_req", {31'b0, mem_req}, {31'b0, (m_mode == 1)});
         if (m_mode == 1) chk("mem_addr", {16'b0, mem_addr}, {16'b0, m_addr});
      end
   end

   task automatic cycle(input logic r, input logic n, input logic b,
                        input logic [15:0] ba, input logic a);
      @(negedge clk);
      rst_f = r; next = n; br_taken = b; br_addr = ba; mem_ack = a;
   endtask

   task automatic wait_irv();
      int t = 0;
      while (!ir_valid && t < 20) begin
         cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
         t++;
      end
      if (!ir_valid) chk("irv_timeout", {31'b0, ir_valid}, 32'd1);
   endtask

   task automatic fetch_next();
      cycle(1'b0, 1'b1, 1'b0, 16'h0, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
      wait_irv();
   endtask

   initial begin
      logic [31:0] w;
      for (int a = 0; a < 65536; a++) begin
         w = $urandom;
         if ($urandom_range(0, 29) == 0) w[31:28] = 4'hF;
         else w[31:28] = 4'($urandom_range(0, 14));
         mem[a] = w;
      end
      words[0] = 32'h0000_0000; words[1] = 32'h8801_000A; words[2] = 32'h8802_0007;
      words[3] = 32'h8021_3002; words[4] = 32'hF000_0000;
      for (int a = 0; a < 5; a++) mem[a] = words[a];
      mem[16'h0040] = 32'h1234_5678;
      mem[16'h0041] = 32'h2222_3333;
      mem[16'hFFFF] = 32'h5555_AAAA;

      // reset state
      cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
      chk("rst_ir", ir, 32'h0);
      chk("rst_irv", {31'b0, ir_valid}, 32'd0);
      chk("rst_req", {31'b0, mem_req}, 32'd0);
      chk("rst_cnt", {16'b0, instr_cnt}, 32'd0);
      chk_en = 1'b1;

      // program run with immediate acks, retire five cycles after each load
      cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
      for (int k = 0; k < 5; k++) begin
         if (k > 0) begin
            repeat (4) cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
            fetch_next();
         end else begin
            wait_irv();
         end
         chk("seq_ir", ir, words[k]);
         chk("seq_pc", {16'b0, pc}, 32'(k));
      end
      chk("seq_halted", {31'b0, halted}, 32'd1);
      chk("seq_cnt", {16'b0, instr_cnt}, 32'd5);

      // halted unit ignores retire and acks
      cycle(1'b0, 1'b1, 1'b1, 16'h0040, 1'b1);
      repeat (3) cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
      chk("halt_ir", ir, 32'hF000_0000);
      chk("halt_pc", {16'b0, pc}, 32'd4);
      chk("halt_cnt", {16'b0, instr_cnt}, 32'd5);
      chk("halt_req", {31'b0, mem_req}, 32'd0);

      // branch from pc 2, then a slow memory
      cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
      wait_irv();
      fetch_next();
      fetch_next();
      cycle(1'b0, 1'b0, 1'b1, 16'h0040, 1'b1);
      repeat (2) cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
      chk("br_alone_pc", {16'b0, pc}, 32'd2);
      chk("br_alone_req", {31'b0, mem_req}, 32'd0);
      cycle(1'b0, 1'b1, 1'b1, 16'h0040, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
      chk("br_addr", {16'b0, mem_addr}, 32'h0040);
      repeat (2) cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
      chk("slow_req", {31'b0, mem_req}, 32'd1);
      cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
      chk("br_pc", {16'b0, pc}, 32'h0040);
      chk("br_ir", ir, 32'h1234_5678);

      // reset with a coincident ack mid-fetch
      cycle(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
      chk("rack_ir", ir, 32'h0);
      chk("rack_req", {31'b0, mem_req}, 32'd0);
      cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
      chk("rack_addr", {16'b0, mem_addr}, 32'h0);

      // random traffic
      for (int i = 0; i < 3000; i++)
         cycle($urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0,
               1'($urandom_range(0, 1)), 16'($urandom), $urandom_range(0, 1) == 1);

      // wraparound from the top of the address space
      cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
      rst_w = 1'b0;
      cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
      chk("wrap_addr0", {16'b0, mem_addr_w}, 32'hFFFF);
      ack_w = 1'b1;
      cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
      ack_w = 1'b0;
      chk("wrap_pc", {16'b0, pc_w}, 32'hFFFF);
      next_w = 1'b1;
      cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
      next_w = 1'b0;
      chk("wrap_req", {31'b0, mem_req_w}, 32'd1);
      chk("wrap_addr1", {16'b0, mem_addr_w}, 32'h0000);

      chk_en = 1'b0;
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter ADDR_W, default 16: program counter and memory address width in bits.
REQ-002 Parameter RESET_PC, default 0: PC value loaded on reset.
REQ-003 CLK  input  1: single clock; all state SHALL update on the rising edge only.
REQ-004 RST_F  input  1: reset, synchronous and active-high; sampled on the rising edge of CLK.
REQ-005 NEXT  input  1: one-cycle pulse from the sisc control unit meaning "current instruction retired, fetch next".
REQ-006 BR_TAKEN  input  1: qualifies NEXT; when high with NEXT, the next fetch uses BR_ADDR.
REQ-007 BR_ADDR  input  ADDR_W: branch target address.
REQ-008 MEM_REQ  output  1: read request to instruction memory, held high until acknowledged.
REQ-009 MEM_ADDR  output  ADDR_W: read address, stable while MEM_REQ is high.
REQ-010 MEM_ACK  input  1: memory read complete; MEM_DATA valid in the same cycle.
REQ-011 MEM_DATA  input  32: instruction word from memory.
REQ-012 IR  output  32: instruction register driving sisc IR.
REQ-013 IR_VALID  output  1: IR holds a fetched, unretired instruction.
REQ-014 PC  output  ADDR_W: address of the instruction currently in IR.
REQ-015 HALTED  output  1: halt opcode fetched; fetching stopped.
REQ-016 INSTR_CNT  output  16: count of instructions loaded into IR since reset, saturating.

Function
REQ-017 FSM states SHALL be IDLE, FETCH, HOLD, HALT.
REQ-018 IDLE: entered on reset; advances to FETCH on the first cycle RST_F is low, with fetch address = RESET_PC.
REQ-019 FETCH: MEM_REQ=1, MEM_ADDR=fetch address; stays until MEM_ACK=1.
REQ-020 FETCH with MEM_ACK: IR<=MEM_DATA, PC<=fetch address, fetch address<=fetch address+1 (mod 2^ADDR_W), INSTR_CNT+1 saturating at 16'hFFFF, next state HOLD (or HALT per REQ-022).
REQ-021 MEM_ACK in the first FETCH cycle is legal; minimum latency from NEXT to IR_VALID=1 is 2 cycles.
REQ-022 If MEM_DATA[31:28]==4'hF on load, next state HALT; IR is loaded, IR_VALID=1, HALTED=1.
REQ-023 HOLD: IR_VALID=1, MEM_REQ=0; on NEXT, IR_VALID<=0, state<=FETCH; if BR_TAKEN also high, fetch address<=BR_ADDR.
REQ-024 NEXT or BR_TAKEN outside HOLD SHALL be ignored; BR_TAKEN without NEXT SHALL be ignored.
REQ-025 MEM_ACK outside FETCH SHALL be ignored; IR SHALL not change.
REQ-026 HALT is terminal: MEM_REQ=0, IR and PC frozen, NEXT ignored; only reset exits.
REQ-027 PC at 2^ADDR_W-1 SHALL wrap: next sequential fetch address is 0.
REQ-028 Opcode 4'h0 (nop) and all others except 4'hF SHALL be passed through unmodified.

Reset
REQ-029 With RST_F=1 at a rising edge: state<=IDLE, IR<=0, IR_VALID<=0, PC<=RESET_PC, fetch address<=RESET_PC, MEM_REQ<=0, HALTED<=0, INSTR_CNT<=0.
REQ-030 Reset mid-FETCH SHALL drop MEM_REQ the next cycle; a MEM_ACK coincident with reset SHALL not load IR.
REQ-031 Reset SHALL override NEXT, BR_TAKEN and MEM_ACK in the same cycle, and SHALL exit HALT.

Verification
REQ-032 Reset, memory ACKs same cycle, words 00000000, 8801000A, 88020007, 80213002, F0000000 at 0-4, NEXT pulsed 5 cycles after each IR_VALID -> IR shows each word in order, PC 0..4, HALTED=1 after last, INSTR_CNT=5.
REQ-033 MEM_ACK delayed 3 cycles -> MEM_REQ/MEM_ADDR stable 4 cycles, IR_VALID rises the cycle after ACK.
REQ-034 In HOLD at PC=2, NEXT with BR_TAKEN=1, BR_ADDR=0x0040 -> MEM_ADDR=0x0040, then PC=0x0040; BR_TAKEN alone in HOLD -> no change.
REQ-035 RESET_PC=16'hFFFF, no branch -> fetch addresses FFFF then 0000.
REQ-036 RST_F raised during FETCH with concurrent MEM_ACK -> IR=0, IR_VALID=0, MEM_REQ=0 next cycle, fetch restarts at RESET_PC after release.
REQ-037 In HALT, pulse NEXT and MEM_ACK -> IR, PC, INSTR_CNT unchanged, MEM_REQ stays 0.
